// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full, level and sticky overflow for the async FIFO.
// Latency: a push updates every output at its own edge; a read-pointer move shows on outputs at the 3rd wr_clk edge.
// Backpressure: wfull blocks pushes (wr_en while full is dropped and sets wr_ovf); full is pessimistic, never optimistic.
module fifo_wptr_full #(
  parameter int ADDRSIZE     = 8,
  parameter int AFULL_THRESH = 120
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic                wr_en,
  input  logic [ADDRSIZE-1:0] rd_ptr_gray,
  output logic [ADDRSIZE-2:0] wr_addr,
  output logic [ADDRSIZE-1:0] wr_ptr_gray,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE-1:0] wr_level,
  output logic                wr_ovf
);

  localparam logic [ADDRSIZE-1:0] AFULL_LVL = ADDRSIZE'(AFULL_THRESH);

  logic [ADDRSIZE-1:0] wbin;
  logic [ADDRSIZE-1:0] wbin_next;
  logic [ADDRSIZE-1:0] wgray_next;
  logic [ADDRSIZE-1:0] rq1;
  logic [ADDRSIZE-1:0] rq2;
  logic [ADDRSIZE-1:0] rbin_s;
  logic [ADDRSIZE-1:0] level_next;
  logic                push;
  logic                wfull_next;
  logic                walmost_full_next;

  // A push is only taken while not full, so a rejected write leaves the pointer alone.
  assign push       = wr_en & ~wfull;
  assign wbin_next  = wbin + {{(ADDRSIZE-1){1'b0}}, push};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
  assign wfull_next = (wgray_next == {~rq2[ADDRSIZE-1:ADDRSIZE-2], rq2[ADDRSIZE-3:0]});

  // Gray-to-binary of the synced read pointer: bit i is the XOR of all bits from the MSB down to i.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < ADDRSIZE; i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end
  end

  // Occupancy uses the same rq2 as the full test, so wfull and level==D always agree.
  assign level_next        = wbin_next - rbin_s;
  assign walmost_full_next = (level_next >= AFULL_LVL);

  assign wr_addr = wbin[ADDRSIZE-2:0];

  // Two-flop synchronizer for the read pointer; rd_ptr_gray goes straight into rq1.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rd_ptr_gray;
      rq2 <= rq1;
    end
  end

  // Pointer and status registers; reset wins over a simultaneous wr_en.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin         <= '0;
      wr_ptr_gray  <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wr_level     <= '0;
      wr_ovf       <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wr_ptr_gray  <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wr_level     <= level_next;
      if (wr_en && wfull) begin
        wr_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: vector table, directed corner sequences, randomized traffic.
// Every step drives inputs just after a rising edge and checks outputs 1ns after the next rising edge.
// Expected values come from an occupancy-count model (writes minus 2-cycle-delayed reads).
module tb_fifo_wptr_full;

  logic       wr_clk = 1'b0;
  logic       wr_rst = 1'b1;
  logic       wr_en  = 1'b0;
  logic [7:0] rd_ptr_gray = 8'h00;
  logic [6:0] wr_addr;
  logic [7:0] wr_ptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [7:0] wr_level;
  logic       wr_ovf;

  fifo_wptr_full #(.ADDRSIZE(8), .AFULL_THRESH(120)) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .wr_en        (wr_en),
    .rd_ptr_gray  (rd_ptr_gray),
    .wr_addr      (wr_addr),
    .wr_ptr_gray  (wr_ptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wr_level     (wr_level),
    .wr_ovf       (wr_ovf)
  );

  always #5 wr_clk = ~wr_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: count of accepted writes (mod 256) and the read count seen through two flops.
  logic [7:0] m_wc  = 8'd0;
  logic [7:0] m_s1  = 8'd0;
  logic [7:0] m_s2  = 8'd0;
  logic [7:0] m_lvl = 8'd0;
  logic       m_full = 1'b0;
  logic       m_ovf  = 1'b0;

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One wr_clk cycle: drive, advance model at the edge, compare all outputs.
  task automatic cyc(input logic rst, input logic en, input logic [7:0] rdb);
    logic push;
    wr_rst      = rst;
    wr_en       = en;
    rd_ptr_gray = gray(rdb);
    @(posedge wr_clk);
    if (rst) begin
      m_wc = 8'd0; m_s1 = 8'd0; m_s2 = 8'd0; m_lvl = 8'd0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      push = en && !m_full;
      if (en && m_full) m_ovf = 1'b1;
      m_wc   = m_wc + 8'(push);
      m_lvl  = m_wc - m_s2;
      m_full = (m_lvl == 8'd128);
      m_s2   = m_s1;
      m_s1   = rdb;
    end
    #1;
    chk("wr_addr",      32'(wr_addr),      32'(m_wc[6:0]));
    chk("wr_ptr_gray",  32'(wr_ptr_gray),  32'(gray(m_wc)));
    chk("wr_level",     32'(wr_level),     32'(m_lvl));
    chk("wfull",        32'(wfull),        32'(m_full));
    chk("walmost_full", 32'(walmost_full), 32'(m_lvl >= 8'd120));
    chk("wr_ovf",       32'(wr_ovf),       32'(m_ovf));
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] rdb;
    logic [7:0] lvl;
    logic [6:0] addr;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] rdb;
    logic [7:0] prev_g;
    logic       saw_wrap;
    int         tot;

    // Short hand-computed sequence: pushes, a delayed read advance, then a reset.
    tbl[0]  = '{1'b1, 1'b1, 8'd0, 8'd0, 7'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'd0, 8'd1, 7'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'd0, 8'd2, 7'd2, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'd1, 8'd2, 7'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'd1, 8'd2, 7'd2, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'd1, 8'd1, 7'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'd2, 8'd2, 7'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'd2, 8'd3, 7'd4, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'd2, 8'd2, 7'd4, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'd0, 8'd0, 7'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'd0, 8'd1, 7'd1, 1'b0, 1'b0};

    #2;
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].rdb);
      chk("tbl_level", 32'(wr_level), 32'(tbl[i].lvl));
      chk("tbl_addr",  32'(wr_addr),  32'(tbl[i].addr));
      chk("tbl_full",  32'(wfull),    32'(tbl[i].full));
      chk("tbl_ovf",   32'(wr_ovf),   32'(tbl[i].ovf));
    end

    // Reset held 2 cycles with wr_en high: everything stays at zero.
    cyc(1'b1, 1'b1, 8'd0);
    cyc(1'b1, 1'b1, 8'd0);
    chk("rst_addr",  32'(wr_addr), 32'd0);
    chk("rst_level", 32'(wr_level), 32'd0);
    chk("rst_gray",  32'(wr_ptr_gray), 32'd0);

    // Fill 128 entries with the reader parked at 0.
    for (int i = 1; i <= 128; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk("fill_level", 32'(wr_level), 32'(i));
      chk("fill_afull", 32'(walmost_full), 32'(i >= 120));
    end
    chk("full_gray",  32'(wr_ptr_gray), 32'h0C0);
    chk("full_addr",  32'(wr_addr), 32'd0);
    chk("full_flag",  32'(wfull), 32'd1);
    chk("full_level", 32'(wr_level), 32'd128);

    // Overflow: pushes while full are dropped, flag is sticky.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk("ovf_level", 32'(wr_level), 32'd128);
      chk("ovf_addr",  32'(wr_addr), 32'd0);
      chk("ovf_flag",  32'(wr_ovf), 32'd1);
    end
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    chk("ovf_sticky", 32'(wr_ovf), 32'd1);

    // Drain sync: one read becomes visible on the 3rd edge.
    cyc(1'b0, 1'b0, 8'd1);
    chk("drain_e1_full", 32'(wfull), 32'd1);
    cyc(1'b0, 1'b0, 8'd1);
    chk("drain_e2_full", 32'(wfull), 32'd1);
    cyc(1'b0, 1'b0, 8'd1);
    chk("drain_e3_full",  32'(wfull), 32'd0);
    chk("drain_e3_level", 32'(wr_level), 32'd127);
    chk("drain_e3_afull", 32'(walmost_full), 32'd1);

    // Wrap: 300 pushes with the reader trailing 4 behind.
    cyc(1'b1, 1'b0, 8'd0);
    tot = 0;
    saw_wrap = 1'b0;
    prev_g = wr_ptr_gray;
    for (int k = 0; k < 300; k++) begin
      rdb = (tot >= 4) ? 8'(tot - 4) : 8'd0;
      cyc(1'b0, 1'b1, rdb);
      tot++;
      chk("wrap_nofull", 32'(wfull), 32'd0);
      chk("wrap_lvl_le7", 32'(wr_level <= 8'd7), 32'd1);
      chk("wrap_gray_1bit", 32'($countones(prev_g ^ wr_ptr_gray) <= 1), 32'd1);
      if (prev_g == 8'h80 && wr_ptr_gray == 8'h00) saw_wrap = 1'b1;
      prev_g = wr_ptr_gray;
    end
    chk("wrap_80_to_00", 32'(saw_wrap), 32'd1);

    // Mid-operation reset at level 50 with wr_en high.
    cyc(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 8'd0);
    chk("mid_level50", 32'(wr_level), 32'd50);
    cyc(1'b1, 1'b1, 8'd0);
    chk("mid_rst_level", 32'(wr_level), 32'd0);
    chk("mid_rst_addr",  32'(wr_addr), 32'd0);
    chk("mid_rst_full",  32'(wfull), 32'd0);
    chk("mid_rst_ovf",   32'(wr_ovf), 32'd0);
    cyc(1'b0, 1'b1, 8'd0);
    chk("mid_resume_addr", 32'(wr_addr), 32'd1);

    // Random traffic: write-heavy phase then read-heavy phase, rare full resets.
    rdb = 8'd0;
    cyc(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 2400; k++) begin
      logic en;
      logic rst;
      en  = (k < 1200) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        rdb = 8'd0;
      end else if (8'(m_wc - rdb) != 8'd0 &&
                   ((k < 1200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8))) begin
        rdb = rdb + 8'd1;
      end
      cyc(rst, en, rdb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
